nibble_serial_sub: RTL and testbench

//  Multi-cycle N-bit subtractor: computes diff = a - b - bin one nibble per clock.

---
 rtl/nibble_serial_sub.sv | 125 ++++++++++++
 tb/tb_nibble_serial_sub.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub.sv
// Serial N-bit subtractor: one 4-bit subtract per clock, borrow carried in a register.
// Start/done handshake; diff/bout only update on the last nibble.

module fourbitsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] D,
  output logic       bout
);
  logic [4:0] r;
  // A 5-bit difference goes negative exactly when a borrow out is needed.
  assign r    = {1'b0, a} - {1'b0, b} - {4'b0, bin};
  assign D    = r[3:0];
  assign bout = r[4];
endmodule

module nibble_serial_sub #(
  parameter int NIBBLES = 4,
  localparam int W      = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d, b_sr_q, b_sr_d, d_sr_q, d_sr_d;
  logic [W-1:0]  diff_q, diff_d, d_shift;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          brw_q, brw_d, bout_q, bout_d;
  logic [3:0]    sub_d;
  logic          sub_bout;

  fourbitsub u_sub (
    .a    (a_sr_q[3:0]),
    .b    (b_sr_q[3:0]),
    .bin  (brw_q),
    .D    (sub_d),
    .bout (sub_bout)
  );

  // Result nibbles enter at the top so the LSB nibble ends at [3:0].
  generate
    if (NIBBLES == 1) begin : g_one
      assign d_shift = sub_d;
    end else begin : g_many
      assign d_shift = {sub_d, d_sr_q[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          d_sr_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_sr_d = d_shift;
        a_sr_d = a_sr_q >> 4;
        b_sr_d = b_sr_q >> 4;
        brw_d  = sub_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NIBBLES - 1)) begin
          diff_d  = d_shift;
          bout_d  = sub_bout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub at NIBBLES=4: vector table plus
// hand-written sequences for busy-start, reset mid-run and back-to-back issue.

module tb_nibble_serial_sub;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_sub #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  // Issue one op at edge E0 and observe the cycles after edges E0+1..E0+6.
  // If glitch is set, a second start with zero operands is sampled at E0+2.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit glitch, output logic [W-1:0] d_o, output logic b_o);
    int pulses = 0;
    @(negedge clk);
    a = av; b = bv; bin = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
    chk("busy_e0", 32'(busy), 32'd1);
    chk("done_e0", 32'(done), 32'd0);
    d_o = diff; b_o = bout;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
      if (k == N) begin
        d_o = diff; b_o = bout;
        chk("done_at_e4", 32'(done), 32'd1);
      end
      if (k == N + 1) chk("busy_drop_e5", 32'(busy), 32'd0);
      if (k < N) chk("busy_run", 32'(busy), 32'd1);
      if (glitch && k == 1) begin start = 1'b1; a = '0; b = '0; bin = 1'b0; end
      else start = 1'b0;
    end
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  vec_t         vecs[6];
  logic [W-1:0] d_got;
  logic         b_got;
  logic [W:0]   m;
  int           seen;

  initial begin
    vecs[0] = '{16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'h000B, 16'h0007, 1'b1, 16'h0003, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[5] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, d_got, b_got);
      m = model(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk($sformatf("vec%0d_diff", i), 32'(d_got), 32'(vecs[i].exp_diff));
      chk($sformatf("vec%0d_bout", i), 32'(b_got), 32'(vecs[i].exp_bout));
      chk($sformatf("vec%0d_model", i), 32'({b_got, d_got}), 32'(m));
    end

    // Start pulsed while busy must not disturb the in-flight operation.
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, d_got, b_got);
    chk("busy_start_diff", 32'(d_got), 32'h7FFF);
    chk("busy_start_bout", 32'(b_got), 32'd0);
    chk("busy_start_held", 32'(diff), 32'h7FFF);

    // Reset during RUN aborts immediately and suppresses done.
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op(16'h0005, 16'h0002, 1'b0, 1'b0, d_got, b_got);
    chk("post_rst_diff", 32'(d_got), 32'h0003);
    chk("post_rst_bout", 32'(b_got), 32'd0);

    // start held high: re-accepted N+2 cycles after the first accept.
    @(negedge clk);
    a = 16'h0009; b = 16'h0004; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 2 * (N + 2); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == N)     chk("b2b_done1", 32'(done), 32'd1);
      if (k == N + 1) chk("b2b_idle", 32'(busy), 32'd0);
      if (k == N + 2) begin
        chk("b2b_reaccept", 32'(busy), 32'd1);
        start = 1'b0; a = 16'h7777;
      end
      if (k == 2 * N + 2) begin
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_diff2", 32'(diff), 32'h0005);
      end
      if (k == 2 * N + 3) chk("b2b_done2_off", 32'(done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
